serial_adder: RTL

- Parametrised multi-cycle adder. Computes a + b + carry_in over WIDTH/DIGIT clock cycles.
- Each cycle adds one DIGIT-bit slice using a ripple chain of full-adder cells.
- Valid/ready handshakes on input and output let it sit between registered datapath stages.
- Trades latency for area. Adds signed-overflow detection and backpressure, which the combinational half/full adders lack.

---
 rtl/serial_adder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder: sum = a + b + carry_in, DIGIT bits per clock.
// Ports: in_valid/in_ready take a, b, carry_in; out_valid/out_ready
// return sum, carry_out (unsigned) and overflow (signed).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             cout_q, ovf_q;

  logic [DIGIT-1:0] slice;
  logic [DIGIT:0]   cy;
  logic [WIDTH-1:0] sum_nx;
  logic             last;

  assign last = (cnt_q == CW'(STEPS - 1));

  // Ripple chain of full adders over the low slice.
  always_comb begin
    cy    = '0;
    slice = '0;
    cy[0] = c_q;
    for (int i = 0; i < DIGIT; i++) begin
      slice[i] = a_q[i] ^ b_q[i] ^ cy[i];
      cy[i+1]  = (a_q[i] & b_q[i])
               | (cy[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // New slice enters at the MSB end; after STEPS
  // shifts the first slice lands at bit 0.
  assign sum_nx = WIDTH'({slice, sum_q} >> DIGIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            c_q   <= carry_in;
            cnt_q <= '0;
          end
        end
        RUN: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          sum_q <= sum_nx;
          c_q   <= cy[DIGIT];
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            cout_q <= cy[DIGIT];
            // Last slice holds the MSB at its top bit.
            ovf_q  <= cy[DIGIT] ^ cy[DIGIT-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule
